// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: edge-detected writes, FWFT valid/ready read side,
// sticky overrun flag for bytes dropped while full.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overrun,
  input  logic              ovr_clr
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rx_done_q;
  logic              wr_req;
  logic              rd_fire;
  logic              wr_fire;
  logic              drop;

  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  // rx_done may stay high for many cycles; only its rising edge writes
  assign wr_req  = rx_done & ~rx_done_q;
  assign rd_fire = rd_valid & rd_ready;
  assign wr_fire = wr_req & (~full | rd_fire);
  assign drop    = wr_req & full & ~rd_fire;

  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      rx_done_q <= rx_done;
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // a new drop outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based
// reference model driven by directed and random byte streams.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overrun;
  logic              ovr_clr;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_prev;
  logic [7:0] last;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_done(rx_done),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .count(count),
    .full(full), .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("count", 32'(count), 32'(mq.size()));
    chk("rd_valid", 32'(rd_valid),
        32'(mq.size() != 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic cycle(input logic d,
                       input logic [7:0] b,
                       input logic rdy,
                       input logic clr);
    bit rf, wq, dr;
    @(negedge clk);
    rx_done = d; rx_data = b;
    rd_ready = rdy; ovr_clr = clr;
    #1;
    if (mq.size() != 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    rf = (mq.size() != 0) && rdy;
    wq = d && !m_prev;
    dr = wq && (mq.size() == DEPTH) && !rf;
    if (rf) last = mq.pop_front();
    if (wq && !dr) mq.push_back(b);
    if (dr) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_prev = d;
    @(posedge clk);
    #1;
    chk_state();
  endtask

  task automatic do_reset(input logic d);
    @(negedge clk);
    rst_n = 1'b0;
    rx_done = d; rx_data = 8'h00;
    rd_ready = 1'b0; ovr_clr = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    m_ovr = 1'b0;
    m_prev = 1'b0;
    chk_state();
    rst_n = 1'b1;
  endtask

  task automatic put(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b0, b, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_data = '0;
    rd_ready = 1'b0; ovr_clr = 1'b0;
    m_ovr = 1'b0; m_prev = 1'b0; last = '0;

    // 1: single byte, then empty + write + ready
    do_reset(1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t1_data", 32'(rd_data), 32'h A5);
    chk("t1_count", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t1_empty_wr", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 2: long rx_done level -> one entry
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_count", 32'(count), 32'd1);

    // 3: fill, overrun, set-beats-clear, drain, clear
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) put(8'(8'h10 + i));
    chk("t3_full", 32'(full), 32'd1);
    put(8'hEE);
    chk("t3_ovr", 32'(overrun), 32'd1);
    cycle(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("t3_set_wins", 32'(overrun), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_last", 32'(last), 32'h1F);
    chk("t3_drained", 32'(rd_valid), 32'd0);
    chk("t3_ovr_kept", 32'(overrun), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_ovr_clr", 32'(overrun), 32'd0);

    // 4: write into full FIFO while reading
    for (int i = 0; i < 16; i++) put(8'(8'h40 + i));
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_ovr", 32'(overrun), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_last", 32'(last), 32'h77);

    // 5: random stream with random ready
    do_reset(1'b0);
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      b = 8'($urandom_range(200, 10));
      for (int k = 0; k <= int'($urandom_range(1, 0)); k++)
        cycle(1'b1, b, 1'($urandom_range(1, 0)), 1'b0);
      for (int k = 0; k <= int'($urandom_range(1, 0)); k++)
        cycle(1'b0, 8'($urandom), 1'($urandom_range(1, 0)), 1'b0);
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_empty", 32'(rd_valid), 32'd0);

    // 6: reset with 5 stored, rx_done held through reset
    for (int i = 0; i < 5; i++) put(8'(8'h60 + i));
    chk("t6_count5", 32'(count), 32'd5);
    do_reset(1'b1);
    cycle(1'b1, 8'h9A, 1'b0, 1'b0);
    chk("t6_rel_wr", 32'(count), 32'd1);
    cycle(1'b1, 8'h9B, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_last", 32'(last), 32'h9A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
